// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction-fetch stage.
//   NOP_INSTR_DEF  default bubble encoding (addi x0,x0,0)
//   RESET_PC_DEF   default fetch address after reset
//   fetch_state_e  fetch FSM states (S_RUN / S_DRAIN)
//   fetch_entry_t  {PC, instruction} pair held in the fetch FIFO
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_DRAIN = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small circular FIFO of {PC, instruction} entries.
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   i_push       write i_data (accepted when not full, or full with a pop)
//   i_data       {pc, instr} entry
//   i_pop        drop the head entry (ignored when empty)
//   i_flush      empty the FIFO; has priority over push/pop
//   o_head       head entry (valid when !o_empty)
//   o_count      number of entries, 0..DEPTH
//   o_full       count == DEPTH
//   o_empty      count == 0
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [63:0]                i_data,
  input  logic                       i_pop,
  input  logic                       i_flush,
  output logic [63:0]                o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_V = CW'(DEPTH);

  logic [63:0]   r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == DEPTH_V);
  assign o_empty   = (r_count == '0);
  assign w_do_pop  = i_pop && !o_empty;
  // A push into a full FIFO is fine when the head leaves in the same cycle.
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage is not reset; entries are only read when counted as valid.
  always_ff @(posedge clk) begin
    if (!reset && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch.sv
// fetch: instruction-fetch stage feeding decode.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   i_pipe_stall          hold the output pipeline register
//   i_Redirect            taken branch/jump from execute: flush and refetch
//   i_RedirectPC          redirect target (bits [1:0] ignored)
//   o_ImemReq/o_ImemAddr  instruction memory request and word address
//   i_ImemGnt             request accepted this cycle
//   i_ImemRValid/RData    in-order response, at least one cycle after grant
//   o_pipe_PC             PC of the presented instruction
//   o_pipe_Instruction    instruction to decode (NOP_INSTR for bubbles)
//   o_pipe_Valid          1 = real instruction, 0 = bubble
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pipe_stall,
  input  logic        i_Redirect,
  input  logic [31:0] i_RedirectPC,
  output logic        o_ImemReq,
  output logic [31:0] o_ImemAddr,
  input  logic        i_ImemGnt,
  input  logic        i_ImemRValid,
  input  logic [31:0] i_ImemRData,
  output logic [31:0] o_pipe_PC,
  output logic [31:0] o_pipe_Instruction,
  output logic        o_pipe_Valid
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW:0] DEPTH_V = (CW+1)'(FIFO_DEPTH);

  fetch_state_e  r_state, w_state_next;
  logic [31:0]   r_fetch_pc;
  logic          r_outstanding;
  logic [31:0]   r_req_pc;
  logic [31:0]   r_pipe_pc;
  logic [31:0]   r_pipe_instr;
  logic          r_pipe_valid;

  logic          w_resp;
  logic          w_push;
  logic          w_pop;
  logic          w_grant;
  logic          w_room;
  logic [CW:0]   w_occ;
  logic [31:0]   w_redirect_pc;
  fetch_entry_t  w_push_entry;
  fetch_entry_t  w_head_entry;
  logic [63:0]   w_head;
  logic [CW-1:0] w_count;
  logic          w_full;
  logic          w_empty;

  assign w_redirect_pc = i_RedirectPC & ~32'h0000_0003;
  assign w_resp        = i_ImemRValid && r_outstanding;
  assign w_pop         = !i_Redirect && !i_pipe_stall && !w_empty;
  assign w_push        = w_resp && (r_state == S_RUN) && !i_Redirect
                         && (!w_full || w_pop);
  assign w_push_entry  = '{pc: r_req_pc, instr: i_ImemRData};
  assign w_head_entry  = fetch_entry_t'(w_head);

  // Entries already buffered plus the one in flight, minus the one leaving.
  assign w_occ  = {1'b0, w_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
  assign w_room = (w_occ < DEPTH_V);

  always_comb begin
    w_state_next = r_state;
    o_ImemReq    = 1'b0;
    case (r_state)
      S_RUN: begin
        o_ImemReq = !reset && !i_Redirect && (!r_outstanding || i_ImemRValid)
                    && w_room;
        if (i_Redirect && r_outstanding && !i_ImemRValid) w_state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (w_resp) w_state_next = S_RUN;
      end
      default: w_state_next = S_RUN;
    endcase
  end

  assign w_grant    = o_ImemReq && i_ImemGnt;
  assign o_ImemAddr = r_fetch_pc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RUN;
    else       r_state <= w_state_next;
  end

  // A grant and a redirect never coincide, so any response (kept or dropped)
  // simply retires the outstanding request unless a new one replaces it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= 1'b0;
      r_req_pc      <= '0;
    end else begin
      if (i_Redirect)   r_fetch_pc <= w_redirect_pc;
      else if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;

      if (w_grant) begin
        r_outstanding <= 1'b1;
        r_req_pc      <= r_fetch_pc;
      end else if (w_resp) begin
        r_outstanding <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe_pc    <= '0;
      r_pipe_instr <= NOP_INSTR;
      r_pipe_valid <= 1'b0;
    end else if (i_Redirect) begin
      r_pipe_instr <= NOP_INSTR;
      r_pipe_valid <= 1'b0;
    end else if (!i_pipe_stall) begin
      if (!w_empty) begin
        r_pipe_pc    <= w_head_entry.pc;
        r_pipe_instr <= w_head_entry.instr;
        r_pipe_valid <= 1'b1;
      end else begin
        r_pipe_instr <= NOP_INSTR;
        r_pipe_valid <= 1'b0;
      end
    end
  end

  assign o_pipe_PC          = r_pipe_pc;
  assign o_pipe_Instruction = r_pipe_instr;
  assign o_pipe_Valid       = r_pipe_valid;

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (i_Redirect),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

endmodule

// File: tb/tb_fetch.sv
// tb_fetch: directed bench for the fetch stage with a simple latency-
// configurable instruction memory responder.
module tb_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_pipe_stall;
  logic        i_Redirect;
  logic [31:0] i_RedirectPC;
  logic        o_ImemReq;
  logic [31:0] o_ImemAddr;
  logic        i_ImemGnt;
  logic        i_ImemRValid;
  logic [31:0] i_ImemRData;
  logic [31:0] o_pipe_PC;
  logic [31:0] o_pipe_Instruction;
  logic        o_pipe_Valid;

  int          total = 0;
  int          bad   = 0;
  int          lat   = 1;
  bit          pend  = 1'b0;
  logic [31:0] pend_addr = '0;
  int          pend_wait = 0;

  always #5 clk = ~clk;

  fetch #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_pipe_stall       (i_pipe_stall),
    .i_Redirect         (i_Redirect),
    .i_RedirectPC       (i_RedirectPC),
    .o_ImemReq          (o_ImemReq),
    .o_ImemAddr         (o_ImemAddr),
    .i_ImemGnt          (i_ImemGnt),
    .i_ImemRValid       (i_ImemRValid),
    .i_ImemRData        (i_ImemRData),
    .o_pipe_PC          (o_pipe_PC),
    .o_pipe_Instruction (o_pipe_Instruction),
    .o_pipe_Valid       (o_pipe_Valid)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    return 32'hC0DE_0000 | a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] pc,
                         input logic [31:0] ins, input logic v);
    chk({tag, ".pc"},    o_pipe_PC,          pc);
    chk({tag, ".instr"}, o_pipe_Instruction, ins);
    chk({tag, ".valid"}, {31'd0, o_pipe_Valid}, {31'd0, v});
  endtask

  task automatic chk_req(input string tag, input logic req, input logic [31:0] addr);
    chk({tag, ".req"}, {31'd0, o_ImemReq}, {31'd0, req});
    if (req) chk({tag, ".addr"}, o_ImemAddr, addr);
  endtask

  // One clock: note any grant before the edge, then update the responder.
  task automatic tick();
    bit          g;
    logic [31:0] a;
    @(negedge clk);
    g = o_ImemReq && i_ImemGnt;
    a = o_ImemAddr;
    @(posedge clk);
    #1;
    i_ImemRValid = 1'b0;
    if (g) begin
      pend      = 1'b1;
      pend_addr = a;
      pend_wait = lat - 1;
    end
    if (pend) begin
      if (pend_wait == 0) begin
        i_ImemRValid = 1'b1;
        i_ImemRData  = imem(pend_addr);
        pend         = 1'b0;
      end else begin
        pend_wait--;
      end
    end
  endtask

  initial begin
    reset        = 1'b1;
    i_pipe_stall = 1'b0;
    i_Redirect   = 1'b0;
    i_RedirectPC = '0;
    i_ImemGnt    = 1'b1;
    i_ImemRValid = 1'b0;
    i_ImemRData  = '0;

    #1 chk_req("in_reset", 1'b0, 32'h0);
    tick(); tick();
    chk_out("reset", 32'h0, NOP, 1'b0);

    // Streaming with single-cycle memory
    reset = 1'b0;
    #1 chk_req("first_req", 1'b1, 32'h0);
    tick();
    #1 chk_req("req4", 1'b1, 32'h4);
    chk_out("preA1", 32'h0, NOP, 1'b0);
    tick();
    #1 chk_req("req8", 1'b1, 32'h8);
    chk_out("preA2", 32'h0, NOP, 1'b0);
    tick();
    chk_out("A", 32'h0, 32'hC0DE_0000, 1'b1);
    tick();
    chk_out("B", 32'h4, 32'hC0DE_0004, 1'b1);

    // Stall while B is presented
    i_pipe_stall = 1'b1;
    #1 chk_req("stall_full", 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("stallB", 32'h4, 32'hC0DE_0004, 1'b1);
      #1 chk_req("stall_noreq", 1'b0, 32'h0);
    end

    // Stall drops; grant withheld at 0x10
    i_pipe_stall = 1'b0;
    i_ImemGnt    = 1'b0;
    #1 chk_req("nognt0", 1'b1, 32'h10);
    tick();
    chk_out("C", 32'h8, 32'hC0DE_0008, 1'b1);
    #1 chk_req("nognt1", 1'b1, 32'h10);
    tick();
    chk_out("D", 32'hC, 32'hC0DE_000C, 1'b1);
    #1 chk_req("nognt2", 1'b1, 32'h10);
    tick();
    chk_out("bubble1", 32'hC, NOP, 1'b0);
    #1 chk_req("nognt3", 1'b1, 32'h10);
    tick();
    chk_out("bubble2", 32'hC, NOP, 1'b0);

    // Redirect to 0x100 while 0x10 is outstanding (3-cycle memory)
    i_ImemGnt = 1'b1;
    lat       = 3;
    #1 chk_req("regrant", 1'b1, 32'h10);
    tick();
    #1 chk_req("outstanding", 1'b0, 32'h0);
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h0000_0100;
    #1 chk_req("redir_noreq", 1'b0, 32'h0);
    tick();
    i_Redirect = 1'b0;
    chk("redir_nop.instr", o_pipe_Instruction, NOP);
    chk("redir_nop.valid", {31'd0, o_pipe_Valid}, 32'd0);
    #1 chk_req("drain1", 1'b0, 32'h0);
    tick();
    #1 chk_req("drain_rvalid", 1'b0, 32'h0);
    lat = 1;
    tick();
    #1 chk_req("after_drain", 1'b1, 32'h100);
    chk("after_drain.valid", {31'd0, o_pipe_Valid}, 32'd0);
    tick();
    chk("no_stale1.valid", {31'd0, o_pipe_Valid}, 32'd0);
    tick();
    chk("no_stale2.valid", {31'd0, o_pipe_Valid}, 32'd0);
    tick();
    chk_out("I100", 32'h100, 32'hC0DE_0100, 1'b1);

    // Redirect to 0x203 while stalled, with a response in the same cycle
    i_pipe_stall = 1'b1;
    i_Redirect   = 1'b1;
    i_RedirectPC = 32'h0000_0203;
    tick();
    i_Redirect = 1'b0;
    chk("stall_redir.instr", o_pipe_Instruction, NOP);
    chk("stall_redir.valid", {31'd0, o_pipe_Valid}, 32'd0);
    #1 chk_req("stall_redir_addr", 1'b1, 32'h200);
    i_pipe_stall = 1'b0;
    tick();
    chk("I200_pre1.valid", {31'd0, o_pipe_Valid}, 32'd0);
    tick();
    chk("I200_pre2.valid", {31'd0, o_pipe_Valid}, 32'd0);
    lat = 3;
    tick();
    chk_out("I200", 32'h200, 32'hC0DE_0200, 1'b1);

    // Reset with a request outstanding and an entry buffered
    i_pipe_stall = 1'b1;
    #1 chk_req("pre_reset", 1'b0, 32'h0);
    tick();
    chk_out("pre_reset_hold", 32'h200, 32'hC0DE_0200, 1'b1);
    reset = 1'b1;
    #1 chk_req("in_reset2", 1'b0, 32'h0);
    tick();
    reset        = 1'b0;
    i_ImemGnt    = 1'b0;
    i_pipe_stall = 1'b0;
    lat          = 1;
    chk_out("after_reset", 32'h0, NOP, 1'b0);
    #1 chk_req("restart", 1'b1, 32'h0);
    tick();
    #1 chk_req("restart2", 1'b1, 32'h0);
    tick();
    chk_out("late_ignored", 32'h0, NOP, 1'b0);
    i_ImemGnt = 1'b1;
    tick(); tick(); tick();
    chk_out("restartA", 32'h0, 32'hC0DE_0000, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
